// File: rtl/stereo_disparity_engine.sv
// Block-matching stereo engine: per block, SAD over MAX_DISP right-image candidates, writes the argmin disparity.
// Optional: define SBM_COST_OUT_EN to add the res_cost output carrying the winning SAD.
module stereo_disparity_engine #(
    parameter int BLOCK_COLS    = 320,
    parameter int BLOCK_ROWS    = 40,
    parameter int PIX_PER_BLOCK = 6,
    parameter int PIX_W         = 8,
    parameter int MAX_DISP      = 16,
    parameter int RD_LAT        = 2
) (
    input  logic                                          clk_100mhz,
    input  logic                                          sys_rst_n,
    input  logic                                          start,
    output logic                                          busy,
    output logic                                          done,
    output logic [$clog2(BLOCK_COLS*BLOCK_ROWS)-1:0]      left_addr,
    output logic [$clog2(BLOCK_COLS*BLOCK_ROWS)-1:0]      right_addr,
    input  logic [PIX_PER_BLOCK*PIX_W-1:0]                left_dout,
    input  logic [PIX_PER_BLOCK*PIX_W-1:0]                right_dout,
    output logic [$clog2(BLOCK_COLS*BLOCK_ROWS)-1:0]      res_addr,
    output logic [$clog2(MAX_DISP)-1:0]                   res_disp,
    output logic                                          res_we
`ifdef SBM_COST_OUT_EN
    ,
    output logic [PIX_W+$clog2(PIX_PER_BLOCK):0]          res_cost
`endif
);

    localparam int AW     = $clog2(BLOCK_COLS*BLOCK_ROWS);
    localparam int WORD_W = PIX_PER_BLOCK*PIX_W;
    localparam int DW     = $clog2(MAX_DISP);
    localparam int CSTW   = PIX_W + $clog2(PIX_PER_BLOCK) + 1;
    localparam int CW     = (BLOCK_COLS > 1) ? $clog2(BLOCK_COLS) : 1;
    localparam int RW     = (BLOCK_ROWS > 1) ? $clog2(BLOCK_ROWS) : 1;
    localparam int CYW    = $clog2(MAX_DISP + RD_LAT + 4);

    // Per-block cycle offsets relative to t0 (the left-address cycle)
    localparam logic [CYW-1:0] CY_LEFT       = CYW'(RD_LAT);
    localparam logic [CYW-1:0] CY_ISSUE_LAST = CYW'(MAX_DISP - 1);
    localparam logic [CYW-1:0] CY_DATA_LO    = CYW'(RD_LAT + 1);
    localparam logic [CYW-1:0] CY_DATA_HI    = CYW'(RD_LAT + MAX_DISP);
    localparam logic [CYW-1:0] CY_LAST_CMP   = CYW'(RD_LAT + MAX_DISP + 2);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, WRITE} state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d, done_q, done_d, res_we_q, res_we_d;
    logic [AW-1:0]     left_addr_q, left_addr_d, right_addr_q, right_addr_d;
    logic [AW-1:0]     res_addr_q, res_addr_d;
    logic [DW-1:0]     res_disp_q, res_disp_d, cost_idx_q, cost_idx_d, best_idx_q, best_idx_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CYW-1:0]    cyc_q, cyc_d;
    logic [WORD_W-1:0] left_word_q, left_word_d;
    logic [CSTW-1:0]   cost_q, cost_d, best_cost_q, best_cost_d, sad;
    logic              cost_v_q, cost_v_d;
    logic [PIX_W-1:0]  lpix, rpix;
    int                rcol;
`ifdef SBM_COST_OUT_EN
    logic [CSTW-1:0]   res_cost_q, res_cost_d;
`endif

    function automatic logic [AW-1:0] blk_addr(input int c, input int r);
        return AW'(BLOCK_ROWS * c + r);
    endfunction

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        res_we_d     = 1'b0;
        left_addr_d  = left_addr_q;
        right_addr_d = right_addr_q;
        res_addr_d   = res_addr_q;
        res_disp_d   = res_disp_q;
        col_d        = col_q;
        row_d        = row_q;
        cyc_d        = cyc_q;
        left_word_d  = left_word_q;
        cost_d       = cost_q;
        cost_idx_d   = cost_idx_q;
        cost_v_d     = 1'b0;
        best_cost_d  = best_cost_q;
        best_idx_d   = best_idx_q;
`ifdef SBM_COST_OUT_EN
        res_cost_d   = res_cost_q;
`endif
        sad  = '0;
        lpix = '0;
        rpix = '0;
        rcol = 0;

        if ((state_q == ISSUE || state_q == DRAIN) && cyc_q == CY_LEFT)
            left_word_d = left_dout;

        for (int unsigned i = 0; i < PIX_PER_BLOCK; i++) begin
            lpix = left_word_q[i*PIX_W +: PIX_W];
            rpix = right_dout[i*PIX_W +: PIX_W];
            sad  = sad + CSTW'((lpix > rpix) ? lpix - rpix : rpix - lpix);
        end

        // Right data for candidate d arrives at cycle RD_LAT+1+d; candidates past column 0 are disqualified
        if (state_q != IDLE && cyc_q >= CY_DATA_LO && cyc_q <= CY_DATA_HI) begin
            cost_v_d   = 1'b1;
            cost_idx_d = DW'(cyc_q - CY_DATA_LO);
            cost_d     = (int'(cost_idx_d) > int'(col_q)) ? '1 : sad;
        end

        if (cost_v_q && (cost_idx_q == '0 || cost_q < best_cost_q)) begin
            best_cost_d = cost_q;
            best_idx_d  = cost_idx_q;
        end

        case (state_q)
            IDLE: begin
                if (done_q) begin
                    busy_d = 1'b0;
                end else if (start) begin
                    state_d     = ISSUE;
                    busy_d      = 1'b1;
                    row_d       = '0;
                    col_d       = '0;
                    cyc_d       = '0;
                    left_addr_d = '0;
                end
            end
            ISSUE: begin
                cyc_d = cyc_q + 1'b1;
                rcol  = int'(col_q) - int'(cyc_q);
                if (rcol < 0)
                    rcol = 0;
                right_addr_d = blk_addr(rcol, int'(row_q));
                if (cyc_q == CY_ISSUE_LAST)
                    state_d = DRAIN;
            end
            DRAIN: begin
                cyc_d = cyc_q + 1'b1;
                if (cyc_q == CY_LAST_CMP) begin
                    state_d    = WRITE;
                    res_we_d   = 1'b1;
                    res_addr_d = blk_addr(int'(col_q), int'(row_q));
                    res_disp_d = best_idx_q;
`ifdef SBM_COST_OUT_EN
                    res_cost_d = best_cost_q;
`endif
                end
            end
            WRITE: begin
                cyc_d   = '0;
                state_d = ISSUE;
                if (col_q == CW'(BLOCK_COLS - 1)) begin
                    col_d = '0;
                    if (row_q == RW'(BLOCK_ROWS - 1)) begin
                        row_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
                if (state_d == ISSUE)
                    left_addr_d = blk_addr(int'(col_d), int'(row_d));
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            res_we_q     <= 1'b0;
            left_addr_q  <= '0;
            right_addr_q <= '0;
            res_addr_q   <= '0;
            res_disp_q   <= '0;
            col_q        <= '0;
            row_q        <= '0;
            cyc_q        <= '0;
            left_word_q  <= '0;
            cost_q       <= '0;
            cost_idx_q   <= '0;
            cost_v_q     <= 1'b0;
            best_cost_q  <= '0;
            best_idx_q   <= '0;
`ifdef SBM_COST_OUT_EN
            res_cost_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            res_we_q     <= res_we_d;
            left_addr_q  <= left_addr_d;
            right_addr_q <= right_addr_d;
            res_addr_q   <= res_addr_d;
            res_disp_q   <= res_disp_d;
            col_q        <= col_d;
            row_q        <= row_d;
            cyc_q        <= cyc_d;
            left_word_q  <= left_word_d;
            cost_q       <= cost_d;
            cost_idx_q   <= cost_idx_d;
            cost_v_q     <= cost_v_d;
            best_cost_q  <= best_cost_d;
            best_idx_q   <= best_idx_d;
`ifdef SBM_COST_OUT_EN
            res_cost_q   <= res_cost_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign res_we     = res_we_q;
    assign left_addr  = left_addr_q;
    assign right_addr = right_addr_q;
    assign res_addr   = res_addr_q;
    assign res_disp   = res_disp_q;
`ifdef SBM_COST_OUT_EN
    assign res_cost   = res_cost_q;
`endif

endmodule

// File: tb/tb_stereo_disparity_engine.sv
// Randomized self-checking bench for stereo_disparity_engine against a behavioural SAD/argmin model.
module tb_stereo_disparity_engine;

    localparam int BC   = 8;
    localparam int BR   = 2;
    localparam int PPB  = 6;
    localparam int PW   = 8;
    localparam int MD   = 4;
    localparam int RL   = 2;
    localparam int NB   = BC * BR;
    localparam int WW   = PPB * PW;
    localparam int AW   = $clog2(NB);
    localparam int DW   = $clog2(MD);
    localparam int CSTW = PW + $clog2(PPB) + 1;
    localparam int PERIOD   = MD + RL + 4;
    localparam int FIRST_WE = 1 + MD + RL + 3;
    localparam int LAST_WE  = FIRST_WE + (NB - 1) * PERIOD;
    localparam int DONE_CYC = LAST_WE + 1;

    logic          clk, sys_rst_n, start, busy, done, res_we;
    logic [AW-1:0] left_addr, right_addr, res_addr;
    logic [WW-1:0] left_dout = '0, right_dout = '0, lp1 = '0, rp1 = '0;
    logic [DW-1:0] res_disp;
`ifdef SBM_COST_OUT_EN
    logic [CSTW-1:0] res_cost;
`endif

    logic [WW-1:0] lmem [NB];
    logic [WW-1:0] rmem [NB];
    int exp_disp [NB];
    int exp_cost [NB];
    int checks = 0;
    int errors = 0;

    stereo_disparity_engine #(
        .BLOCK_COLS(BC), .BLOCK_ROWS(BR), .PIX_PER_BLOCK(PPB),
        .PIX_W(PW), .MAX_DISP(MD), .RD_LAT(RL)
    ) dut (
        .clk_100mhz(clk), .sys_rst_n(sys_rst_n), .start(start),
        .busy(busy), .done(done),
        .left_addr(left_addr), .right_addr(right_addr),
        .left_dout(left_dout), .right_dout(right_dout),
        .res_addr(res_addr), .res_disp(res_disp), .res_we(res_we)
`ifdef SBM_COST_OUT_EN
        , .res_cost(res_cost)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame buffers with a two-stage read pipeline
    always @(posedge clk) begin
        lp1        <= lmem[left_addr];
        rp1        <= rmem[right_addr];
        left_dout  <= lp1;
        right_dout <= rp1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model_cost(input int r, input int c, input int d);
        logic [WW-1:0] lw, rw;
        int s, a, b;
        if (d > c) return (1 << CSTW) - 1;
        lw = lmem[BR * c + r];
        rw = rmem[BR * (c - d) + r];
        s = 0;
        for (int i = 0; i < PPB; i++) begin
            a = int'(lw[i*PW +: PW]);
            b = int'(rw[i*PW +: PW]);
            s += (a > b) ? a - b : b - a;
        end
        return s;
    endfunction

    task automatic build_model();
        int r, c, cst;
        for (int k = 0; k < NB; k++) begin
            r = k / BC;
            c = k % BC;
            exp_disp[k] = 0;
            exp_cost[k] = model_cost(r, c, 0);
            for (int d = 1; d < MD; d++) begin
                cst = model_cost(r, c, d);
                if (cst < exp_cost[k]) begin
                    exp_cost[k] = cst;
                    exp_disp[k] = d;
                end
            end
        end
    endtask

    function automatic logic [WW-1:0] rand_word(input int maxv, input int add);
        logic [WW-1:0] w;
        for (int i = 0; i < PPB; i++)
            w[i*PW +: PW] = PW'($urandom_range(maxv, 0) + add);
        return w;
    endfunction

    // mode 0: all zero; 1: right(c) = left(c+shift); 2: independent random; 3: right(c) = left(c+shift) + 10 per pixel
    task automatic fill_images(input int mode, input int shift);
        for (int a = 0; a < NB; a++) begin
            lmem[a] = (mode == 0) ? '0 : rand_word(mode == 3 ? 200 : 255, 0);
            rmem[a] = (mode == 0) ? '0 : rand_word(255, 0);
        end
        if (mode == 1 || mode == 3) begin
            for (int r = 0; r < BR; r++)
                for (int c = 0; c + shift < BC; c++) begin
                    rmem[BR * c + r] = lmem[BR * (c + shift) + r];
                    if (mode == 3)
                        for (int i = 0; i < PPB; i++)
                            rmem[BR * c + r][i*PW +: PW] = lmem[BR * (c + shift) + r][i*PW +: PW] + PW'(10);
                end
        end
        build_model();
    endtask

    task automatic run_frame(input bit inject_start);
        int n;
        bit seen_done;
        n = 0;
        seen_done = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int rel = 1; rel <= DONE_CYC + 20 && !seen_done; rel++) begin
            if (inject_start)
                start = (rel == 50);
            check_eq("busy", busy, rel <= DONE_CYC);
            if (res_we) begin
                if (n < NB) begin
                    check_eq("we_cycle", rel, FIRST_WE + n * PERIOD);
                    check_eq("res_addr", res_addr, BR * (n % BC) + n / BC);
                    check_eq("res_disp", res_disp, exp_disp[n]);
`ifdef SBM_COST_OUT_EN
                    check_eq("res_cost", res_cost, exp_cost[n]);
`endif
                end else begin
                    check_eq("extra_we", n, NB - 1);
                end
                n++;
            end
            if (done) begin
                seen_done = 1'b1;
                check_eq("done_cycle", rel, DONE_CYC);
            end
            if (!seen_done)
                @(negedge clk);
        end
        start = 1'b0;
        check_eq("done_seen", seen_done, 1);
        check_eq("n_writes", n, NB);
        @(negedge clk);
        check_eq("busy_after", busy, 0);
        check_eq("done_after", done, 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_we"}, res_we, 0);
        check_eq({tag, "_laddr"}, left_addr, 0);
        check_eq({tag, "_raddr"}, right_addr, 0);
        check_eq({tag, "_resaddr"}, res_addr, 0);
        check_eq({tag, "_disp"}, res_disp, 0);
`ifdef SBM_COST_OUT_EN
        check_eq({tag, "_cost"}, res_cost, 0);
`endif
    endtask

    task automatic abort_frame();
        int n;
        n = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 20 * PERIOD && n < 5; t++) begin
            if (res_we)
                n++;
            @(negedge clk);
        end
        check_eq("abort_reached_blk5", n, 5);
        repeat (3) @(negedge clk);
        sys_rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        @(negedge clk);
        check_eq("midrst_we_held", res_we, 0);
        sys_rst_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (res_we)
                check_eq("we_after_abort", res_we, 0);
        end
        check_eq("idle_after_abort", busy, 0);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        start     = 1'b0;
        fill_images(0, 0);
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        sys_rst_n = 1'b1;
        @(negedge clk);

        run_frame(1'b1);
        fill_images(1, 3);
        run_frame(1'b0);
        fill_images(2, 0);
        run_frame(1'b0);
        fill_images(2, 0);
        abort_frame();
        run_frame(1'b0);
`ifdef SBM_COST_OUT_EN
        fill_images(3, 2);
        run_frame(1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stereo_disparity_engine.md
STEREO_DISPARITY_ENGINE -- requirements
Module: stereo_disparity_engine

Interface
REQ-001 SHALL have parameter BLOCK_COLS, default 320: blocks per image row.
REQ-002 SHALL have parameter BLOCK_ROWS, default 40: block rows per image.
REQ-003 SHALL have parameter PIX_PER_BLOCK, default 6: pixels per memory word.
REQ-004 SHALL have parameter PIX_W, default 8: bits per pixel; word width WORD_W = PIX_PER_BLOCK*PIX_W.
REQ-005 SHALL have parameter MAX_DISP, default 16: candidate disparities 0..MAX_DISP-1.
REQ-006 SHALL have parameter RD_LAT, default 2: frame-buffer read latency in cycles.
REQ-007 clk_100mhz  in  1  sole clock, rising edge.
REQ-008 sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-009 start  in  1  single-cycle frame request.
REQ-010 busy  out  1  frame in progress.
REQ-011 done  out  1  single-cycle end-of-frame pulse.
REQ-012 left_addr, right_addr  out  AW=$clog2(BLOCK_COLS*BLOCK_ROWS)  read addresses.
REQ-013 left_dout, right_dout  in  WORD_W  read data, valid RD_LAT cycles after address.
REQ-014 res_addr  out  AW  result address; res_disp  out  $clog2(MAX_DISP)  disparity; res_we  out  1  write strobe.

Function
REQ-015 Address of block (row r, col c) SHALL be BLOCK_ROWS*c + r, for frame buffers and results alike.
REQ-016 Scan order SHALL be r outer 0..BLOCK_ROWS-1, c inner 0..BLOCK_COLS-1.
REQ-017 FSM states SHALL be IDLE, ISSUE, DRAIN, WRITE; IDLE->ISSUE on start; ISSUE->DRAIN after last right address; DRAIN->WRITE when final cost compared; WRITE->ISSUE (next block) or ->IDLE after last block.
REQ-018 start SHALL be ignored unless state is IDLE.
REQ-019 busy SHALL rise the cycle after start is sampled and fall in the done cycle.
REQ-020 Per block: left address in cycle t0 (first t0 = cycle after start), right address for disparity d in cycle t0+1+d, right column = c-d clamped to 0.
REQ-021 Cost(d) SHALL be sum over pixels of |L_i - R_i|, unsigned, width PIX_W+$clog2(PIX_PER_BLOCK)+1, no overflow.
REQ-022 Cost(d) SHALL be forced to all-ones when d > c.
REQ-023 res_disp SHALL be the argmin of cost; ties resolve to the smaller d.
REQ-024 res_we SHALL pulse one cycle at t0+MAX_DISP+RD_LAT+3 with res_addr of the block; next block's t0 SHALL be the following cycle.
REQ-025 done SHALL pulse in the cycle after the last res_we.
REQ-026 No backpressure: res_we SHALL never be delayed.

Reset
REQ-027 While sys_rst_n low: state IDLE, busy=0, done=0, res_we=0, all addresses, res_disp and counters 0, in-flight reads discarded.
REQ-028 Reset mid-frame SHALL abort without a further res_we; next start SHALL begin at block (0,0).

Configuration
REQ-029 Macro SBM_COST_OUT_EN defined: extra output res_cost (cost width) SHALL carry the winning cost, valid with res_we, reset 0.
REQ-030 Macro undefined: res_cost port and its register SHALL be absent; all other behaviour identical.

Verification (BLOCK_COLS=8, BLOCK_ROWS=2, MAX_DISP=4, RD_LAT=2, PIX_PER_BLOCK=6)
REQ-031 Identical all-zero images, start -> 16 writes, every res_disp=0 (tie rule).
REQ-032 Right word at col c equals left word at col c+3 (distinct random words) -> res_disp=3 for c>=3.
REQ-033 Column 0 with arbitrary data -> res_disp=0 (d>0 forced all-ones).
REQ-034 start in cycle 0 -> busy high cycles 1..161, first res_we cycle 10, period 10, last res_we cycle 160, done cycle 161; start at cycle 50 ignored.
REQ-035 sys_rst_n low during block 5 -> all outputs 0 immediately; re-start -> first res_addr=0.
REQ-036 SBM_COST_OUT_EN defined, every pixel differing by 10 at best disparity -> res_cost=60.
